// File: rtl/stopwatch_ctrl.sv
// Mode and display-scan controller for the MM:SS stopwatch: input conditioning,
// RUN/PAUSE/ADJ_MIN/ADJ_SEC mode FSM, increment strobes and blinking anode scan.
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_LEN = 4,
    parameter int unsigned BLINK_LEN    = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_scan,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    output logic       sec_inc,
    output logic       min_adj_inc,
    output logic       sec_adj_inc,
    output logic [3:0] an,
    output logic [1:0] digit_sel,
    output logic [1:0] led,
    output logic       paused
);

    localparam int unsigned DB_W = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
    localparam int unsigned BL_W = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LEN - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_LEN - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_ADJ_MIN = 2'd2,
        ST_ADJ_SEC = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizers for the asynchronous button and switches
    // ------------------------------------------------------------------
    logic [1:0] pb_sync_q;
    logic [1:0] adj_sync_q;
    logic [1:0] sel_sync_q;
    logic       pb_s;
    logic       adj_s;
    logic       sel_s;

    // Shift raw inputs through two flops each
    always_ff @(posedge clk) begin
        if (reset) begin
            pb_sync_q  <= 2'b00;
            adj_sync_q <= 2'b00;
            sel_sync_q <= 2'b00;
        end else begin
            pb_sync_q  <= {pb_sync_q[0], pause_btn};
            adj_sync_q <= {adj_sync_q[0], adj};
            sel_sync_q <= {sel_sync_q[0], sel};
        end
    end

    assign pb_s  = pb_sync_q[1];
    assign adj_s = adj_sync_q[1];
    assign sel_s = sel_sync_q[1];

    // ------------------------------------------------------------------
    // Pause button debounce, sampled at the scan rate
    // ------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            db_level_q;
    logic            db_level_d;
    logic            db_prev_q;
    logic            pause_pulse;

    // Count consecutive differing samples; adopt the new level once stable
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        if (tick_scan) begin
            if (pb_s != db_level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_level_d = pb_s;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    // Debounce state and edge-detect history
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
        end else begin
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
        end
    end

    assign pause_pulse = db_level_q & ~db_prev_q;

    // ------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    logic   was_paused_q;
    logic   was_paused_d;
    logic   in_adj;
    logic   enter_adj;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            was_paused_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            was_paused_q <= was_paused_d;
        end
    end

    // Next-state logic: adjust switch dominates, pause toggles only outside adjust
    always_comb begin
        state_d      = state_q;
        was_paused_d = was_paused_q;
        unique case (state_q)
            ST_RUN: begin
                if (adj_s) begin
                    state_d      = sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                    was_paused_d = 1'b0;
                end else if (pause_pulse) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (adj_s) begin
                    state_d      = sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                    was_paused_d = 1'b1;
                end else if (pause_pulse) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJ_MIN, ST_ADJ_SEC: begin
                if (adj_s) begin
                    state_d = sel_s ? ST_ADJ_SEC : ST_ADJ_MIN;
                end else begin
                    state_d = was_paused_q ? ST_PAUSE : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign in_adj    = (state_q == ST_ADJ_MIN) | (state_q == ST_ADJ_SEC);
    assign enter_adj = ((state_d == ST_ADJ_MIN) | (state_d == ST_ADJ_SEC))
                       & (state_d != state_q);

    // ------------------------------------------------------------------
    // Increment strobes, decoded from the pre-transition state
    // ------------------------------------------------------------------
    logic sec_inc_q;
    logic min_adj_inc_q;
    logic sec_adj_inc_q;

    // Register one strobe per qualifying tick
    always_ff @(posedge clk) begin
        if (reset) begin
            sec_inc_q     <= 1'b0;
            min_adj_inc_q <= 1'b0;
            sec_adj_inc_q <= 1'b0;
        end else begin
            sec_inc_q     <= tick_1hz & (state_q == ST_RUN);
            min_adj_inc_q <= tick_2hz & (state_q == ST_ADJ_MIN);
            sec_adj_inc_q <= tick_2hz & (state_q == ST_ADJ_SEC);
        end
    end

    assign sec_inc     = sec_inc_q;
    assign min_adj_inc = min_adj_inc_q;
    assign sec_adj_inc = sec_adj_inc_q;

    // ------------------------------------------------------------------
    // Digit scan and blink timing
    // ------------------------------------------------------------------
    logic [1:0]      digit_sel_q;
    logic [1:0]      digit_sel_d;
    logic [BL_W-1:0] blink_cnt_q;
    logic [BL_W-1:0] blink_cnt_d;
    logic            blink_phase_q;
    logic            blink_phase_d;
    logic            blank;

    // Advance scan index; blink restarts visible on every entry into adjust
    always_comb begin
        digit_sel_d   = digit_sel_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick_scan) begin
            digit_sel_d = digit_sel_q + 2'd1;
        end
        if (enter_adj) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (tick_scan) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
        end
    end

    // Scan and blink registers
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_sel_q   <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            digit_sel_q   <= digit_sel_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Blank the digit pair under adjustment during the off half of the blink
    always_comb begin
        blank = 1'b0;
        if (blink_phase_q) begin
            if ((state_q == ST_ADJ_MIN) && digit_sel_q[1]) begin
                blank = 1'b1;
            end
            if ((state_q == ST_ADJ_SEC) && !digit_sel_q[1]) begin
                blank = 1'b1;
            end
        end
    end

    assign an        = blank ? 4'b1111 : ~(4'b0001 << digit_sel_q);
    assign digit_sel = digit_sel_q;
    assign led       = {state_q == ST_ADJ_MIN, state_q == ST_ADJ_SEC};
    assign paused    = (state_q == ST_PAUSE) | (in_adj & was_paused_q);

endmodule
